cmp_nbit_seq: RTL and testbench
===============================

Name: cmp_nbit_seq

Overview:
- Parametrised, multi-cycle magnitude/equality comparator for the ALU datapath. Successor to the 2-bit equality comparator.
- Compares two WIDTH-bit operands SLICE bits per clock, MSB slice first.
- Reports equal / greater / less in equality, unsigned or signed mode, under a start/busy/done handshake.
- Sits beside the ALU core. The ALU control FSM launches compares and samples the results on done.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 2, bits compared per clock; 1 <= SLICE <= WIDTH.
- NS (localparam), WIDTH/SLICE, number of compare cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a compare; sampled only in IDLE or DONE.
- mode  in  2  00 equality, 01 unsigned, 10 signed, 11 reserved (treated as unsigned); captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high while a compare is in progress.
- done  out  1  single-cycle pulse; results valid.
- aeqb  out  1  A == B.
- agtb  out  1  A > B (modes 01/10/11 only).
- altb  out  1  A < B (modes 01/10/11 only).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, aeqb, agtb, altb = 0; internal regs cleared. Reset mid-compare aborts it; no done is produced.
- States:
  - IDLE: start=1 -> capture a, b, mode into shift regs; clear decided flag and slice counter; go to RUN.
  - RUN: one slice per cycle. Stays NS cycles, then goes to DONE.
  - DONE: lasts one cycle with done=1. start=1 here is accepted exactly as in IDLE (back-to-back operation) and goes to RUN. Otherwise goes to IDLE.
- Signed mode: invert the MSB of both operands at capture (offset-binary), then compare as unsigned.
- Per RUN cycle:
  - Compare the top SLICE bits of both shift regs.
  - If decided=0 and the slices differ: set decided=1 and latch gt = (slice_a > slice_b).
  - Once decided=1, later slices are ignored. The most significant differing slice wins.
  - Shift both regs left by SLICE; increment the counter.
- Latency: start accepted at edge E0. busy=1 from E0 through edge E0+NS-1. At edge E0+NS: busy=0, done=1, and results update together.
- Results:
  - aeqb = ~decided.
  - agtb = decided & gt; altb = decided & ~gt.
  - In mode 00, agtb and altb are forced to 0.
  - Exactly one of aeqb/agtb/altb is 1 in non-equality modes.
  - Results hold until the next done or reset.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- a, b and mode changing during RUN have no effect.
- NS=1 (SLICE=WIDTH): RUN lasts one cycle; latency is 1.

Decomposition:
- Shared package/header cmp_pkg:
  - mode encodings CMP_EQ=2'b00, CMP_UNS=2'b01, CMP_SGN=2'b10;
  - state encodings S_IDLE, S_RUN, S_DONE.
- One sub-module: cmp_slice. Combinational, SLICE-bit parameter, inputs x, y, outputs eq and gt. It generalises the bitwise-equality-and-AND structure to SLICE bits and adds greater-than.
- Counter width is clog2(NS) with a minimum of 1.

Test Plan (WIDTH=16, SLICE=2, NS=8):
- mode=01, a=b=16'h1234, start pulse -> busy high 8 cycles; done at edge E0+8; aeqb=1, agtb=0, altb=0.
- a=16'h8000, b=16'h7FFF: mode=01 -> agtb=1; repeat with mode=10 -> altb=1.
- mode=00, a=16'h0001, b=16'h0002 -> aeqb=0, agtb=0, altb=0; mode=11 with same operands -> altb=1.
- a=16'h4001, b=16'h3FFF, mode=01 -> agtb=1. The MSB slice decides despite lower slices favouring B.
- Second start pulse at cycle 3 of RUN is ignored; done occurs only once at E0+8. A start held in the DONE cycle is accepted, and the second done arrives 8 cycles later.
- rst_n=0 at RUN cycle 4 -> next edge busy=0, done=0, results=0; no done follows. A new compare after release completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential slice-serial magnitude comparator.
// Mode and state codes live here so the ALU control FSM can import the same names.
package cmp_pkg;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_UNS = 2'b01;
  localparam logic [1:0] CMP_SGN = 2'b10;
  localparam logic [1:0] CMP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } cmp_state_e;

  // A single-cycle compare still needs a one-bit counter.
  function automatic int cnt_width(input int ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit comparator: per-bit XNOR reduced with AND for equality,
// plus an unsigned greater-than decided by the most significant differing bit.
module cmp_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             eq,
  output logic             gt
);

  logic [SLICE-1:0] bit_eq;

  assign bit_eq = ~(x ^ y);
  assign eq     = &bit_eq;

  // Scan LSB to MSB so the highest differing bit has the final say.
  always_comb begin
    gt = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      if (!bit_eq[i]) begin
        gt = x[i];
      end
    end
  end

endmodule

// File: rtl/cmp_nbit_seq.sv
// Slice-serial equality/unsigned/signed comparator with a start/busy/done handshake.
// Operands are shifted out MSB slice first; the first differing slice decides the result.
module cmp_nbit_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int NS    = WIDTH / SLICE;
  localparam int CNT_W = cnt_width(NS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;

  logic             slice_eq;
  logic             slice_gt;

  cmp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .x  (a_q[WIDTH-1 -: SLICE]),
    .y  (b_q[WIDTH-1 -: SLICE]),
    .eq (slice_eq),
    .gt (slice_gt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    aeqb_d    = aeqb_q;
    agtb_d    = agtb_q;
    altb_d    = altb_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Signed operands become offset-binary so the unsigned slice compare orders them.
          a_d       = a;
          b_d       = b;
          if (mode == CMP_SGN) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          mode_d    = mode;
          cnt_d     = '0;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          state_d   = S_RUN;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_RUN: begin
        if (!decided_q && !slice_eq) begin
          decided_d = 1'b1;
          gt_d      = slice_gt;
        end
        a_d   = a_q << SLICE;
        b_d   = b_q << SLICE;
        cnt_d = cnt_q + 1'b1;
        // The last slice's verdict is folded in here so results land with done.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          aeqb_d  = ~decided_d;
          agtb_d  = decided_d &  gt_d & (mode_q != CMP_EQ);
          altb_d  = decided_d & ~gt_d & (mode_q != CMP_EQ);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= CMP_EQ;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      aeqb_q    <= 1'b0;
      agtb_q    <= 1'b0;
      altb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      aeqb_q    <= aeqb_d;
      agtb_q    <= agtb_d;
      altb_q    <= altb_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign aeqb = aeqb_q;
  assign agtb = agtb_q;
  assign altb = altb_q;

endmodule

// File: tb/tb_cmp_nbit_seq.sv
// Directed bench for cmp_nbit_seq (WIDTH=16, SLICE=2): table of compares with
// hand-computed verdicts, plus ignored-start, back-to-back and mid-run reset sequences.
module tb_cmp_nbit_seq;

  localparam int WIDTH = 16;
  localparam int SLICE = 2;
  localparam int NS    = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic             agtb;
  logic             altb;

  int compared;
  int mismatched;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             eq;
    logic             gt;
    logic             lt;
  } vec_t;

  vec_t vecs[10];

  cmp_nbit_seq #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .aeqb  (aeqb),
    .agtb  (agtb),
    .altb  (altb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the first negedge after acceptance.
  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic [1:0] vm);
    @(negedge clk);
    a     = va;
    b     = vb;
    mode  = vm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int busy_cnt, output bit got_done);
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  busy_cnt;
    bit  got_done;
    int  done_cnt;
    int  done_at1;
    int  done_at2;
    logic r_eq1;
    logic r_lt2;

    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    a     = '0;
    b     = '0;

    vecs[0] = '{"uns_equal",      16'h1234, 16'h1234, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"uns_8000_7fff",  16'h8000, 16'h7FFF, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"sgn_8000_7fff",  16'h8000, 16'h7FFF, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"eq_mode_diff",   16'h0001, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"rsv_mode_lt",    16'h0001, 16'h0002, 2'b11, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"msb_slice_wins", 16'h4001, 16'h3FFF, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"sgn_neg1_pos1",  16'hFFFF, 16'h0001, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"eq_mode_same",   16'h1234, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{"uns_0_ffff",     16'h0000, 16'hFFFF, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{"sgn_7fff_8000",  16'h7FFF, 16'h8000, 2'b10, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_aeqb", {31'd0, aeqb}, 32'd0);
    checkOutput("reset_agtb", {31'd0, agtb}, 32'd0);
    checkOutput("reset_altb", {31'd0, altb}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].mode);
      waitDone(busy_cnt, got_done);
      checkOutput({vecs[v].name, "_done_seen"}, {31'd0, got_done}, 32'd1);
      checkOutput({vecs[v].name, "_busy_cycles"}, busy_cnt, NS);
      checkOutput({vecs[v].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      checkOutput({vecs[v].name, "_aeqb"}, {31'd0, aeqb}, {31'd0, vecs[v].eq});
      checkOutput({vecs[v].name, "_agtb"}, {31'd0, agtb}, {31'd0, vecs[v].gt});
      checkOutput({vecs[v].name, "_altb"}, {31'd0, altb}, {31'd0, vecs[v].lt});
      @(negedge clk);
      checkOutput({vecs[v].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      checkOutput({vecs[v].name, "_hold"}, {29'd0, aeqb, agtb, altb},
                  {29'd0, vecs[v].eq, vecs[v].gt, vecs[v].lt});
    end

    // Start pulse during RUN with different operands must be ignored.
    applyStimulus(16'h8000, 16'h7FFF, 2'b01);
    done_cnt = 0;
    done_at1 = 0;
    for (int i = 1; i <= 14; i++) begin
      if (done) begin
        done_cnt++;
        done_at1 = i;
      end
      if (i == 3) begin
        start = 1'b1;
        a     = 16'h0000;
        b     = 16'hFFFF;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("ignored_start_done_count", done_cnt, 1);
    checkOutput("ignored_start_done_at", done_at1, NS + 1);
    checkOutput("ignored_start_agtb", {31'd0, agtb}, 32'd1);
    checkOutput("ignored_start_altb", {31'd0, altb}, 32'd0);

    // Start held in the DONE cycle launches the next compare back to back.
    applyStimulus(16'h1234, 16'h1234, 2'b01);
    done_cnt = 0;
    done_at1 = 0;
    done_at2 = 0;
    r_eq1    = 1'b0;
    r_lt2    = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at1 = i;
          r_eq1    = aeqb;
        end else begin
          done_at2 = i;
          r_lt2    = altb;
        end
      end
      if (i == NS + 1) begin
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0002;
        mode  = 2'b01;
      end
      if (i == NS + 2) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b_done_count", done_cnt, 2);
    checkOutput("b2b_first_done_at", done_at1, NS + 1);
    checkOutput("b2b_second_done_at", done_at2, 2 * NS + 2);
    checkOutput("b2b_first_aeqb", {31'd0, r_eq1}, 32'd1);
    checkOutput("b2b_second_altb", {31'd0, r_lt2}, 32'd1);

    // Reset in the middle of RUN aborts the compare and clears the results.
    applyStimulus(16'h0005, 16'h0003, 2'b01);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_results", {29'd0, aeqb, agtb, altb}, 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midreset_no_done", done_cnt, 0);

    applyStimulus(16'h4001, 16'h3FFF, 2'b01);
    waitDone(busy_cnt, got_done);
    checkOutput("post_reset_done_seen", {31'd0, got_done}, 32'd1);
    checkOutput("post_reset_busy_cycles", busy_cnt, NS);
    checkOutput("post_reset_results", {29'd0, aeqb, agtb, altb}, 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
